// File: rtl/if_ctrl_pkg.sv
// Shared types for the fetch controller: FSM states, redirect sources ranked by priority.
package if_ctrl_pkg;
  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    HALT = 2'd3
  } if_ctrl_state_e;

  // Encoding order is the priority order, so a plain compare picks the stronger source.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    JMP  = 2'd1,
    BR   = 2'd2,
    TRAP = 2'd3
  } redir_src_e;
endpackage

// File: rtl/if_ctrl_redirect_arb.sv
// Fixed-priority redirect select (trap > br > jmp); purely combinational.
module redirect_arb
  import if_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            trap_req_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_pc_i,
  input  logic            jmp_req_i,
  input  logic [XLEN-1:0] jmp_pc_i,
  output logic            valid_o,
  output redir_src_e      src_o,
  output logic [XLEN-1:0] pc_o
);
  always_comb begin
    valid_o = 1'b1;
    src_o   = NONE;
    pc_o    = '0;
    if (trap_req_i) begin
      src_o = TRAP;
      pc_o  = trap_pc_i;
    end else if (br_taken_i) begin
      src_o = BR;
      pc_o  = br_pc_i;
    end else if (jmp_req_i) begin
      src_o = JMP;
      pc_o  = jmp_pc_i;
    end else begin
      valid_o = 1'b0;
    end
  end
endmodule

// File: rtl/if_ctrl.sv
// Fetch controller: boot sequencing, redirect arbitration/pending, debug halt.
// Optional perf counters (redirect_cnt, stall_cnt) under IF_CTRL_PERF_EN.
module if_ctrl
  import if_ctrl_pkg::*;
#(
  parameter int              XLEN        = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              BOOT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_pc,
  input  logic            jmp_req,
  input  logic [XLEN-1:0] jmp_pc,
  input  logic            hazard_stall,
  input  logic            imem_busy,
  input  logic            halt_req,
  input  logic            resume_req,
  output logic            if_stall,
  output logic            if_redirect,
  output logic [XLEN-1:0] if_redirect_pc,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic [1:0]      ctrl_state
`ifdef IF_CTRL_PERF_EN
  ,
  output logic [31:0]     redirect_cnt,
  output logic [31:0]     stall_cnt
`endif
);
  localparam int CW = $clog2(BOOT_CYCLES + 1);

  if_ctrl_state_e  state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  redir_src_e      pend_src_q, pend_src_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            redir_q, redir_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fifid_q, fifid_d, fidex_q, fidex_d;
  logic            boot_q, boot_d;

  logic            arb_valid;
  redir_src_e      arb_src;
  logic [XLEN-1:0] arb_pc;
  logic            take;

  redirect_arb #(.XLEN(XLEN)) u_arb (
    .trap_req_i (trap_req),
    .trap_pc_i  (trap_pc),
    .br_taken_i (br_taken),
    .br_pc_i    (br_pc),
    .jmp_req_i  (jmp_req),
    .jmp_pc_i   (jmp_pc),
    .valid_o    (arb_valid),
    .src_o      (arb_src),
    .pc_o       (arb_pc)
  );

  // In PEND only a strictly stronger source displaces the held request.
  assign take = arb_valid && (arb_src > pend_src_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_src_d = pend_src_q;
    pend_pc_d  = pend_pc_q;
    redir_d    = 1'b0;
    pc_d       = pc_q;
    fifid_d    = 1'b0;
    fidex_d    = 1'b0;
    boot_d     = 1'b0;
    unique case (state_q)
      BOOT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == '0) begin
          redir_d = 1'b1;
          pc_d    = RESET_PC;
          boot_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (arb_valid) begin
          if (imem_busy) begin
            pend_src_d = arb_src;
            pend_pc_d  = arb_pc;
            state_d    = PEND;
          end else begin
            redir_d = 1'b1;
            pc_d    = arb_pc;
            fifid_d = 1'b1;
            fidex_d = (arb_src != JMP);
          end
        end else if (halt_req) begin
          state_d = HALT;
        end
      end
      PEND: begin
        if (take) begin
          pend_src_d = arb_src;
          pend_pc_d  = arb_pc;
        end
        if (!imem_busy) begin
          redir_d    = 1'b1;
          pc_d       = pend_pc_d;
          fifid_d    = 1'b1;
          fidex_d    = (pend_src_d != JMP);
          pend_src_d = NONE;
          state_d    = RUN;
        end
      end
      HALT: begin
        if (trap_req) begin
          pend_src_d = TRAP;
          pend_pc_d  = trap_pc;
          state_d    = PEND;
        end else if (resume_req) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      cnt_q      <= CW'(BOOT_CYCLES);
      pend_src_q <= NONE;
      pend_pc_q  <= '0;
      redir_q    <= 1'b0;
      pc_q       <= RESET_PC;
      fifid_q    <= 1'b0;
      fidex_q    <= 1'b0;
      boot_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_src_q <= pend_src_d;
      pend_pc_q  <= pend_pc_d;
      redir_q    <= redir_d;
      pc_q       <= pc_d;
      fifid_q    <= fifid_d;
      fidex_q    <= fidex_d;
      boot_q     <= boot_d;
    end
  end

  // Stall is dropped during a redirect so if_stage actually loads the new PC.
  assign if_stall       = (hazard_stall | imem_busy | (state_q != RUN)) & ~redir_q;
  assign if_redirect    = redir_q;
  assign if_redirect_pc = pc_q;
  assign flush_ifid     = fifid_q;
  assign flush_idex     = fidex_q;
  assign ctrl_state     = state_q;

`ifdef IF_CTRL_PERF_EN
  logic [31:0] rcnt_q, scnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      if (redir_q && !boot_q && (rcnt_q != '1)) rcnt_q <= rcnt_q + 32'd1;
      if (if_stall && ((state_q == RUN) || (state_q == PEND)) && (scnt_q != '1))
        scnt_q <= scnt_q + 32'd1;
    end
  end
  assign redirect_cnt = rcnt_q;
  assign stall_cnt    = scnt_q;
`endif
endmodule

// File: tb/tb_if_ctrl.sv
// Randomized + directed bench for if_ctrl against a cycle-level behavioural model.
module tb_if_ctrl;
  localparam int          XLEN = 32;
  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam int          BC   = 2;

  logic gclk = 1'b0;
  logic grst_n;
  logic trap_req, br_taken, jmp_req, hazard_stall, imem_busy, halt_req, resume_req;
  logic [XLEN-1:0] trap_pc, br_pc, jmp_pc;
  logic if_stall, if_redirect, flush_ifid, flush_idex;
  logic [XLEN-1:0] if_redirect_pc;
  logic [1:0] ctrl_state;
`ifdef IF_CTRL_PERF_EN
  logic [31:0] redirect_cnt, stall_cnt;
`endif

  always #5 gclk = ~gclk;

  if_ctrl #(.XLEN(XLEN), .RESET_PC(RPC), .BOOT_CYCLES(BC)) dut (
    .clk(gclk), .rst_n(grst_n),
    .trap_req(trap_req), .trap_pc(trap_pc),
    .br_taken(br_taken), .br_pc(br_pc),
    .jmp_req(jmp_req), .jmp_pc(jmp_pc),
    .hazard_stall(hazard_stall), .imem_busy(imem_busy),
    .halt_req(halt_req), .resume_req(resume_req),
    .if_stall(if_stall), .if_redirect(if_redirect), .if_redirect_pc(if_redirect_pc),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .ctrl_state(ctrl_state)
`ifdef IF_CTRL_PERF_EN
    , .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
`endif
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Model: mode 0=boot 1=run 2=pending 3=halted; rank 3=trap 2=br 1=jmp 0=none.
  int          m_mode, m_left, m_prank;
  logic [31:0] m_ppc, m_pc;
  bit          m_redir, m_fi, m_fe;

  task automatic m_reset();
    m_mode = 0; m_left = BC; m_prank = 0; m_ppc = 0;
    m_pc = RPC; m_redir = 0; m_fi = 0; m_fe = 0;
  endtask

  task automatic m_step();
    int r; logic [31:0] p;
    r = 0; p = 0;
    if (trap_req)      begin r = 3; p = trap_pc; end
    else if (br_taken) begin r = 2; p = br_pc;   end
    else if (jmp_req)  begin r = 1; p = jmp_pc;  end
    m_redir = 0; m_fi = 0; m_fe = 0;
    case (m_mode)
      0: begin
        m_left--;
        if (m_left == 0) begin m_redir = 1; m_pc = RPC; m_mode = 1; end
      end
      1: begin
        if (r > 0 && imem_busy) begin m_prank = r; m_ppc = p; m_mode = 2; end
        else if (r > 0) begin m_redir = 1; m_pc = p; m_fi = 1; m_fe = (r >= 2); end
        else if (halt_req) m_mode = 3;
      end
      2: begin
        if (r > m_prank) begin m_prank = r; m_ppc = p; end
        if (!imem_busy) begin
          m_redir = 1; m_pc = m_ppc; m_fi = 1; m_fe = (m_prank >= 2);
          m_prank = 0; m_mode = 1;
        end
      end
      default: begin
        if (trap_req) begin m_prank = 3; m_ppc = trap_pc; m_mode = 2; end
        else if (resume_req) m_mode = 1;
      end
    endcase
  endtask

  task automatic check_all(input string ph);
    bit es;
    es = (hazard_stall || imem_busy || m_mode != 1) && !m_redir;
    chk({ph, ".stall"}, {31'd0, if_stall}, {31'd0, es});
    chk({ph, ".redir"}, {31'd0, if_redirect}, {31'd0, m_redir});
    chk({ph, ".pc"}, if_redirect_pc, m_pc);
    chk({ph, ".fifid"}, {31'd0, flush_ifid}, {31'd0, m_fi});
    chk({ph, ".fidex"}, {31'd0, flush_idex}, {31'd0, m_fe});
    chk({ph, ".state"}, {30'd0, ctrl_state}, m_mode[31:0]);
  endtask

  task automatic step(input string ph);
    @(posedge gclk);
    if (grst_n) m_step();
    @(negedge gclk); #1;
    check_all(ph);
  endtask

  task automatic idle();
    trap_req = 0; br_taken = 0; jmp_req = 0; hazard_stall = 0;
    imem_busy = 0; halt_req = 0; resume_req = 0;
  endtask

  task automatic do_reset(input string ph);
    grst_n = 0; #1;
    m_reset();
    check_all(ph);
    step(ph);
    @(negedge gclk); grst_n = 1; #1;
    check_all(ph);
    for (int i = 0; i < BC + 2; i++) step({ph, ".boot"});
  endtask

  initial begin
    idle();
    trap_pc = 32'h100; br_pc = 32'h20; jmp_pc = 32'h40;
    do_reset("rst");

    // br and jmp together: br wins with both flushes
    br_taken = 1; jmp_req = 1; step("brjmp");
    chk("brjmp.pc_exp", if_redirect_pc, 32'h20);
    idle(); step("brjmp"); step("brjmp");

    // jmp held while busy, then trap overwrites it
    imem_busy = 1; jmp_req = 1; step("pend");
    jmp_req = 0; trap_req = 1; step("pend");
    trap_req = 0; step("pend");
    imem_busy = 0; step("pend");
    chk("pend.trap_pc", if_redirect_pc, 32'h100);
    step("pend");

    // halt then resume
    halt_req = 1; step("halt");
    for (int i = 0; i < 5; i++) step("halt");
    halt_req = 0; resume_req = 1; step("resume");
    resume_req = 0; step("resume"); step("resume");

    // trap overrides halt
    trap_pc = 32'h200;
    halt_req = 1; step("htrap"); step("htrap");
    trap_req = 1; step("htrap");
    trap_req = 0; halt_req = 0; step("htrap"); step("htrap");

    // hazard stall, then hazard coinciding with a redirect
    hazard_stall = 1;
    for (int i = 0; i < 3; i++) step("haz");
    hazard_stall = 0; step("haz");
    hazard_stall = 1; br_pc = 32'h80; br_taken = 1; step("hazbr");
    br_taken = 0; step("hazbr"); hazard_stall = 0; step("hazbr");

    // reset while a request is pending
    imem_busy = 1; jmp_req = 1; step("rstpend");
    jmp_req = 0; step("rstpend");
    imem_busy = 0;
    do_reset("rstpend");
    step("rstpend");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      trap_req     = ($urandom_range(0, 9) == 0);
      br_taken     = ($urandom_range(0, 5) == 0);
      jmp_req      = ($urandom_range(0, 4) == 0);
      imem_busy    = ($urandom_range(0, 2) == 0);
      hazard_stall = ($urandom_range(0, 3) == 0);
      halt_req     = ($urandom_range(0, 7) == 0);
      resume_req   = ($urandom_range(0, 5) == 0);
      trap_pc      = $urandom & 32'hFFFF_FFFC;
      br_pc        = $urandom & 32'hFFFF_FFFC;
      jmp_pc       = $urandom & 32'hFFFF_FFFC;
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/if_ctrl.md
# if_ctrl

Fetch controller for `if_stage`. It arbitrates redirect requests from trap, EX-stage branch and ID-stage jump sources, and holds pending redirects while instruction memory is busy. It drives the `stall`/`redirect`/`redirect_pc` inputs of `if_stage` plus pipeline flush strobes, and sequences boot and debug halt.

## Interface
- `XLEN`, 32, address width
- `RESET_PC`, 32'h0000_0000, PC loaded at end of boot
- `BOOT_CYCLES`, 2, stall cycles after reset release before the boot redirect (≥1)
- `clk` in 1 — system clock, rising edge
- `rst_n` in 1 — reset, asynchronous, active-low
- `trap_req` in 1 — trap/exception redirect request
- `trap_pc` in XLEN — trap vector
- `br_taken` in 1 — EX-stage taken branch/mispredict
- `br_pc` in XLEN — branch target
- `jmp_req` in 1 — ID-stage jump
- `jmp_pc` in XLEN — jump target
- `hazard_stall` in 1 — load-use stall from hazard unit
- `imem_busy` in 1 — instruction memory cannot accept a new fetch
- `halt_req` in 1 — debug halt request (level)
- `resume_req` in 1 — debug resume (pulse)
- `if_stall` out 1 — to `if_stage.stall`
- `if_redirect` out 1 — to `if_stage.redirect`
- `if_redirect_pc` out XLEN — to `if_stage.redirect_pc`
- `flush_ifid` out 1 — kill IF/ID register
- `flush_idex` out 1 — kill ID/EX register
- `ctrl_state` out 2 — current FSM state (debug)

## Operation
- FSM states: BOOT=0, RUN=1, PEND=2, HALT=3.
- **BOOT:**
  - A down-counter loads `BOOT_CYCLES`; `if_stall`=1 throughout.
  - When the count reaches 0, assert `if_redirect` for one cycle with `RESET_PC`, then go to RUN.
  - All requests in BOOT are ignored.
- **Priority:** trap > br > jmp. Only the winner is acted on. Lower-priority requests in the same cycle are dropped; their sources re-assert if still valid.
- **RUN, request sampled at edge N, `imem_busy`=0:**
  - `if_redirect`=1 with the winner's PC during cycle N+1 (one cycle, registered).
  - Flushes:
    - trap or br: `flush_ifid`=1 and `flush_idex`=1, same cycle as `if_redirect`.
    - jmp: `flush_ifid` only.
- **RUN, request sampled with `imem_busy`=1:**
  - Latch the winner's PC and source into the pending register; go to PEND.
- **PEND:**
  - `if_stall`=1.
  - A new request of strictly higher priority than the pending one overwrites it; equal or lower priority is ignored.
  - First edge with `imem_busy`=0: issue the redirect and flushes next cycle, return to RUN.
- **HALT:**
  - Enter from RUN when `halt_req`=1 and no redirect request is present.
  - `if_stall`=1 until `resume_req`, then return to RUN with no redirect.
  - `trap_req` in HALT: latch into pending, go to PEND (trap overrides halt).
  - br and jmp are ignored in HALT.
- **Same cycle redirect + `halt_req`:** redirect wins; halt is taken on the next edge if still asserted.
- **`if_stall`** = `hazard_stall` | `imem_busy` | (state≠RUN). It is forced to 0 whenever `if_redirect`=1 so the PC loads.
- **Reset mid-operation:** the pending request, counter and FSM clear immediately; the FSM restarts in BOOT.

## Timing
- Reset values:
  - `if_stall`=1
  - `if_redirect`=0
  - `if_redirect_pc`=`RESET_PC`
  - `flush_ifid`=0, `flush_idex`=0
  - `ctrl_state`=BOOT
- Redirect latency: request at edge N → `if_redirect` high for cycle N+1 → PC = target after edge N+1.
- Boot: first `if_redirect` in cycle `BOOT_CYCLES` after `rst_n` rises (cycle 0 = first edge with `rst_n`=1).
- `if_redirect` and flushes are registered, single-cycle pulses. `if_stall` is combinational from `hazard_stall`/`imem_busy`.
- `if_redirect_pc` holds its last issued value when `if_redirect`=0.

## Configuration
- `IF_CTRL_PERF_EN`:
  - Defined: add outputs `redirect_cnt` and `stall_cnt`, both 32 bit, reset 0, saturating at all-ones.
    - `redirect_cnt` increments each `if_redirect` cycle (boot redirect excluded).
    - `stall_cnt` increments each cycle with `if_stall`=1 in state RUN or PEND.
  - Undefined: neither the ports nor the counters exist.

## Structure
- Package `if_ctrl_pkg`:
  - `if_ctrl_state_e` (BOOT/RUN/PEND/HALT)
  - `redir_src_e` (NONE/JMP/BR/TRAP, ordered by priority)
  - `XLEN_DEF` constant
- Sub-module `redirect_arb`: combinational fixed-priority select returning `{valid, src, pc}`. It is used both for RUN arbitration and for the PEND overwrite compare.

## Test plan
- Reset, `BOOT_CYCLES`=2 → `if_stall`=1 for 2 cycles; `if_redirect`=1 with PC 0x0 in cycle 2; then `ctrl_state`=RUN.
- RUN, `br_taken`+`br_pc`=0x20 and `jmp_req`+`jmp_pc`=0x40 at the same edge → one cycle `if_redirect`, PC 0x20, both flushes=1; jmp dropped.
- `imem_busy`=1, `jmp_pc`=0x40 requested, then `trap_pc`=0x100 while PEND → after busy drops, a single redirect to 0x100 with both flushes.
- `halt_req`=1 → HALT with `if_stall`=1 for 5 cycles; `resume_req` → RUN with no redirect. Repeat with `trap_req` in HALT → redirect to `trap_pc`.
- `hazard_stall`=1 for 3 cycles in RUN → `if_stall`=1 exactly those cycles. Same cycle as an issued redirect → `if_stall`=0 while `if_redirect`=1.
- `rst_n` dropped during PEND → outputs return to reset values asynchronously; after release the pending request is not issued and the boot sequence repeats.
